// File: rtl/seg_display_arbiter_if.sv
// Producer-side bundle of the seven-segment display arbiter: requests and
// patterns in, grant, registered pattern and busy flag out.
interface seg_display_arbiter_if;
  logic [2:0]  i_Req;
  logic [20:0] i_Seg_Data;
  logic [2:0]  o_Grant;
  logic [6:0]  o_Segments;
  logic        o_Busy;

  modport master (
    output i_Req,
    output i_Seg_Data,
    input  o_Grant,
    input  o_Segments,
    input  o_Busy
  );

  modport slave (
    input  i_Req,
    input  i_Seg_Data,
    output o_Grant,
    output o_Segments,
    output o_Busy
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin, time-sliced owner of the single seven-segment digit with a blank gap between owners.
// Optional idle chase animation: define DISPLAY_ARB_IDLE_ANIM_EN.
module seg_display_arbiter #(
  parameter int g_SLICE_CYCLES    = 25000000,
  parameter int g_GAP_CYCLES      = 2,
  parameter int g_IDLE_ANIM_DELAY = 4166666
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  seg_display_arbiter_if.slave  bus
);

  localparam int SLICE_W = $clog2(g_SLICE_CYCLES);
  localparam int GAP_W   = $clog2(g_GAP_CYCLES + 1);
  localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(g_SLICE_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(g_GAP_CYCLES - 1);

  if (g_SLICE_CYCLES < 2 || g_GAP_CYCLES < 1 || g_IDLE_ANIM_DELAY < 0) begin : g_param_check
    $error("seg_display_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          grant_q, grant_d;
  logic [6:0]          seg_q, seg_d;
  logic [1:0]          last_q, last_d;
  logic [SLICE_W-1:0]  slice_q, slice_d;
  logic [GAP_W-1:0]    gap_q, gap_d;

  logic [2:0] winner;
  logic [1:0] owner_idx;
  logic       owner_req;
  logic       other_req;
  logic       expiry;
  logic [6:0] idle_pattern;

  // Search order after the last owner: last+1, last+2, then last itself.
  function automatic logic [2:0] f_pick(input logic [2:0] req, input logic [1:0] last);
    logic [2:0] win;
    logic [1:0] first, second, third;
    win = 3'b000;
    case (last)
      2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
      2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
      default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
    endcase
    if (req[first])       win[first]  = 1'b1;
    else if (req[second]) win[second] = 1'b1;
    else if (req[third])  win[third]  = 1'b1;
    return win;
  endfunction

  function automatic logic [1:0] f_owner_idx(input logic [2:0] grant);
    case (grant)
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [6:0] f_seg_of(input logic [20:0] data, input logic [1:0] idx);
    case (idx)
      2'd1:    return data[13:7];
      2'd2:    return data[20:14];
      default: return data[6:0];
    endcase
  endfunction

  assign winner    = f_pick(bus.i_Req, last_q);
  assign owner_idx = f_owner_idx(grant_q);
  assign owner_req = |(bus.i_Req & grant_q);
  assign other_req = |(bus.i_Req & ~grant_q);
  assign expiry    = (slice_q == SLICE_LAST);

`ifdef DISPLAY_ARB_IDLE_ANIM_EN
  localparam int ANIM_W = (g_IDLE_ANIM_DELAY > 0) ? $clog2(g_IDLE_ANIM_DELAY + 1) : 1;
  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(g_IDLE_ANIM_DELAY);

  logic [2:0]        anim_q;
  logic [ANIM_W-1:0] anim_cnt_q;

  // Held at segment A outside IDLE so every idle period starts the chase from the top.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      anim_q     <= 3'd0;
      anim_cnt_q <= '0;
    end else if (state_q != S_IDLE) begin
      anim_q     <= 3'd0;
      anim_cnt_q <= '0;
    end else if (anim_cnt_q == ANIM_LAST) begin
      anim_cnt_q <= '0;
      anim_q     <= (anim_q == 3'd5) ? 3'd0 : anim_q + 3'd1;
    end else begin
      anim_cnt_q <= anim_cnt_q + 1'b1;
    end
  end

  assign idle_pattern = 7'd1 << anim_q;
`else
  assign idle_pattern = 7'd0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    seg_d   = seg_q;
    last_d  = last_q;
    slice_d = slice_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        grant_d = winner;
        slice_d = '0;
        seg_d   = idle_pattern;
        if (|winner) begin
          state_d = S_OWN;
          seg_d   = 7'd0;
        end
      end
      S_OWN: begin
        // A drop that coincides with expiry takes the same release path.
        if (!owner_req || (expiry && other_req)) begin
          state_d = S_GAP;
          grant_d = 3'b000;
          seg_d   = 7'd0;
          last_d  = owner_idx;
          gap_d   = '0;
        end else begin
          seg_d   = f_seg_of(bus.i_Seg_Data, owner_idx);
          slice_d = expiry ? '0 : slice_q + 1'b1;
        end
      end
      S_GAP: begin
        grant_d = 3'b000;
        seg_d   = 7'd0;
        if (gap_q == GAP_LAST) begin
          grant_d = winner;
          slice_d = '0;
          state_d = (|winner) ? S_OWN : S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 3'b000;
        seg_d   = 7'd0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_IDLE;
      grant_q <= 3'b000;
      seg_q   <= 7'd0;
      last_q  <= 2'd2;
      slice_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      seg_q   <= seg_d;
      last_q  <= last_d;
      slice_q <= slice_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.o_Grant    = grant_q;
  assign bus.o_Segments = seg_q;
  assign bus.o_Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed and randomized bench for seg_display_arbiter against a cycle-level behavioural model.
// Animation expectations follow DISPLAY_ARB_IDLE_ANIM_EN when it is defined.
module tb_seg_display_arbiter;
  localparam int SLICE = 8;
  localparam int GAP   = 2;
  localparam int DELAY = 3;

  logic i_Clk = 1'b0;
  logic i_Rst_L;
  seg_display_arbiter_if bus();

  seg_display_arbiter #(
    .g_SLICE_CYCLES   (SLICE),
    .g_GAP_CYCLES     (GAP),
    .g_IDLE_ANIM_DELAY(DELAY)
  ) dut (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .bus    (bus)
  );

  always #5 i_Clk = ~i_Clk;

  int checks = 0;
  int errors = 0;

  // Model: owner index (-1 none), cycles held, remaining blank cycles, last owner, animation.
  int         m_owner, m_last, m_held, m_gap_left, m_anim_pos, m_anim_ticks;
  logic [6:0] e_seg;
  logic       pin1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_winner(input logic [2:0] req, input int last);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last + k) % 3;
      if (req[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 2; m_held = 0; m_gap_left = 0;
    m_anim_pos = 0; m_anim_ticks = 0; e_seg = 7'd0;
  endtask

  task automatic model_edge();
    logic [2:0]  r;
    logic [20:0] d;
    logic        others;
    int          w;
    r = bus.i_Req;
    d = bus.i_Seg_Data;
    if (m_owner >= 0) begin
      others = (r & ~(3'b001 << m_owner)) != 3'b000;
      if (!r[m_owner[1:0]] || (((m_held + 1) % SLICE) == 0 && others)) begin
        m_last = m_owner; m_owner = -1; m_gap_left = GAP; e_seg = 7'd0;
      end else begin
        e_seg = 7'((d >> (7 * m_owner)) & 21'h7F);
        m_held++;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
      e_seg = 7'd0;
      if (m_gap_left == 0) begin
        w = ref_winner(r, m_last);
        if (w >= 0) begin m_owner = w; m_held = 0; end
      end
    end else begin
      w = ref_winner(r, m_last);
      if (w >= 0) begin
        m_owner = w; m_held = 0; e_seg = 7'd0; m_anim_pos = 0; m_anim_ticks = 0;
      end else begin
`ifdef DISPLAY_ARB_IDLE_ANIM_EN
        e_seg = 7'(1 << m_anim_pos);
        m_anim_ticks++;
        if (m_anim_ticks == DELAY + 1) begin
          m_anim_ticks = 0;
          m_anim_pos = (m_anim_pos + 1) % 6;
        end
`else
        e_seg = 7'd0;
`endif
      end
    end
  endtask

  task automatic check_outputs();
    logic [2:0] eg;
    eg = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    chk("grant", 32'(bus.o_Grant), 32'(eg));
    chk("segments", 32'(bus.o_Segments), 32'(e_seg));
    chk("busy", 32'(bus.o_Busy), 32'((m_owner >= 0) || (m_gap_left > 0)));
    chk("grant_onehot0", 32'($onehot0(bus.o_Grant)), 32'd1);
  endtask

  function automatic logic [20:0] rand_data();
    logic [20:0] v;
    v = 21'($urandom);
    if (pin1) v[13:7] = 7'h5B;
    return v;
  endfunction

  task automatic step();
    @(posedge i_Clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n, input logic [2:0] req);
    bus.i_Req = req;
    for (int i = 0; i < n; i++) begin
      bus.i_Seg_Data = rand_data();
      step();
    end
  endtask

  task automatic async_reset();
    #3;
    i_Rst_L = 1'b0;
    #1;
    chk("rst_grant", 32'(bus.o_Grant), 32'd0);
    chk("rst_segments", 32'(bus.o_Segments), 32'd0);
    chk("rst_busy", 32'(bus.o_Busy), 32'd0);
    model_reset();
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
  endtask

  task automatic settle();
    int n;
    n = 0;
    bus.i_Req = 3'b000;
    while ((m_owner >= 0 || m_gap_left > 0) && n < 40) begin
      bus.i_Seg_Data = rand_data();
      step();
      n++;
    end
    chk("settle_idle", 32'(bus.o_Busy), 32'd0);
  endtask

  initial begin
    int         held;
    logic [2:0] prev;
    logic [2:0] seq[$];
    logic [6:0] exp_anim;

    i_Rst_L = 1'b0;
    bus.i_Req = 3'b000;
    bus.i_Seg_Data = '0;
    pin1 = 1'b0;
    model_reset();
    repeat (2) @(posedge i_Clk);
    #1;
    chk("reset_grant", 32'(bus.o_Grant), 32'd0);
    chk("reset_segments", 32'(bus.o_Segments), 32'd0);
    chk("reset_busy", 32'(bus.o_Busy), 32'd0);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;

    // Single requester 1 with a fixed pattern.
    pin1 = 1'b1;
    bus.i_Req = 3'b010;
    bus.i_Seg_Data = rand_data();
    step();
    chk("t1_grant", 32'(bus.o_Grant), 32'h2);
    bus.i_Seg_Data = rand_data();
    step();
    chk("t1_segments", 32'(bus.o_Segments), 32'h5B);
    chk("t1_busy", 32'(bus.o_Busy), 32'd1);
    pin1 = 1'b0;
    settle();

    // Owner 0 pre-empted at slice expiry by producer 2.
    bus.i_Req = 3'b001;
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) bus.i_Req = 3'b101;
      bus.i_Seg_Data = rand_data();
      step();
      if (bus.o_Grant === 3'b001) held++;
    end
    chk("t2_slice_len", 32'(held), 32'd8);
    chk("t2_gap_blank", 32'(bus.o_Segments), 32'd0);
    bus.i_Seg_Data = rand_data();
    step();
    chk("t2_next_owner", 32'(bus.o_Grant), 32'h4);
    settle();

    // All three requesting: strict rotation.
    bus.i_Req = 3'b111;
    prev = 3'b000;
    for (int i = 0; i < 45; i++) begin
      bus.i_Seg_Data = rand_data();
      step();
      if (bus.o_Grant !== 3'b000 && bus.o_Grant !== prev) seq.push_back(bus.o_Grant);
      if (bus.o_Grant !== 3'b000) prev = bus.o_Grant;
    end
    chk("t3_rotations", 32'(seq.size() >= 4), 32'd1);
    if (seq.size() >= 4) begin
      chk("t3_rot0", 32'(seq[0]), 32'h1);
      chk("t3_rot1", 32'(seq[1]), 32'h2);
      chk("t3_rot2", 32'(seq[2]), 32'h4);
      chk("t3_rot3", 32'(seq[3]), 32'h1);
    end
    settle();

    // Sole owner keeps the display across slice boundaries.
    run(1, 3'b001);
    held = 0;
    for (int i = 0; i < 30; i++) begin
      bus.i_Seg_Data = rand_data();
      step();
      if (bus.o_Grant === 3'b001 && bus.o_Busy === 1'b1) held++;
    end
    chk("t4_const_grant", 32'(held), 32'd30);
    bus.i_Req = 3'b000;
    step();
    chk("t4_gap1_grant", 32'(bus.o_Grant), 32'd0);
    chk("t4_gap1_busy", 32'(bus.o_Busy), 32'd1);
    step();
    chk("t4_gap2_busy", 32'(bus.o_Busy), 32'd1);
    step();
    chk("t4_idle_busy", 32'(bus.o_Busy), 32'd0);

    // Asynchronous reset mid-ownership, then producer 0 has priority.
    run(3, 3'b001);
    async_reset();
    bus.i_Req = 3'b101;
    bus.i_Seg_Data = rand_data();
    step();
    chk("t5_first_grant", 32'(bus.o_Grant), 32'h1);
    settle();

    // Pulse lying entirely inside the gap is ignored.
    run(3, 3'b001);
    bus.i_Req = 3'b000;
    step();
    bus.i_Req = 3'b010;
    step();
    bus.i_Req = 3'b000;
    step();
    chk("gap_pulse_grant", 32'(bus.o_Grant), 32'd0);
    chk("gap_pulse_busy", 32'(bus.o_Busy), 32'd0);

    // Idle display from a fresh reset, then after an ownership episode.
    async_reset();
    for (int i = 1; i <= 28; i++) begin
      step();
`ifdef DISPLAY_ARB_IDLE_ANIM_EN
      exp_anim = 7'(1 << (((i - 1) / 4) % 6));
`else
      exp_anim = 7'd0;
`endif
      chk("t6_idle_pattern", 32'(bus.o_Segments), 32'(exp_anim));
    end
    run(3, 3'b010);
    settle();
    step();
`ifdef DISPLAY_ARB_IDLE_ANIM_EN
    exp_anim = 7'h01;
`else
    exp_anim = 7'h00;
`endif
    chk("t6_restart", 32'(bus.o_Segments), 32'(exp_anim));

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) bus.i_Req = 3'($urandom);
      bus.i_Seg_Data = rand_data();
      step();
      if (i == 200) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
